// File: rtl/dispatch_queue.sv
// In-order dispatch buffer between Rename and the ROB / reservation stations.
// Optional same-cycle bypass when empty: define DISPATCH_QUEUE_BYPASS_EN.
module dispatch_queue #(
  parameter int DEPTH     = 4,
  parameter int NUM_FU    = 3,
  parameter int FU_W      = 2,
  parameter int PREG_W    = 6,
  parameter int TAG_W     = 4,
  parameter int PAYLOAD_W = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         ren_valid_i,
  output logic                         ren_ready_o,
  input  logic [FU_W-1:0]              ren_fu_i,
  input  logic [PAYLOAD_W-1:0]         ren_payload_i,
  input  logic [PREG_W-1:0]            ren_rs1_p_i,
  input  logic [PREG_W-1:0]            ren_rs2_p_i,
  input  logic [PREG_W-1:0]            ren_rd_new_p_i,
  input  logic [PREG_W-1:0]            ren_rd_old_p_i,
  input  logic                         rob_full_i,
  input  logic [TAG_W-1:0]             rob_alloc_tag_i,
  output logic                         rob_push_o,
  output logic                         rob_illegal_o,
  input  logic [NUM_FU-1:0]            rs_ready_i,
  output logic [NUM_FU-1:0]            disp_valid_o,
  output logic [PAYLOAD_W-1:0]         disp_payload_o,
  output logic [PREG_W-1:0]            disp_rs1_p_o,
  output logic [PREG_W-1:0]            disp_rs2_p_o,
  output logic [PREG_W-1:0]            disp_rd_p_o,
  output logic [PREG_W-1:0]            disp_rd_old_p_o,
  output logic [TAG_W-1:0]             disp_rob_tag_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  // Handshake: an instruction transfers from Rename on any cycle where
  // ren_valid_i && ren_ready_o; a dispatch happens on any cycle where
  // rob_push_o is high, and the selected entry leaves the queue that cycle.

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = $clog2(DEPTH+1);
  localparam int NUM_SLOT = 2**FU_W;

  typedef struct packed {
    logic [FU_W-1:0]      fu;
    logic [PAYLOAD_W-1:0] payload;
    logic [PREG_W-1:0]    rs1;
    logic [PREG_W-1:0]    rs2;
    logic [PREG_W-1:0]    rd_new;
    logic [PREG_W-1:0]    rd_old;
  } entry_t;

  entry_t               mem [DEPTH];
  logic [PTR_W-1:0]     head, tail;
  logic [CNT_W-1:0]     count;
  logic [NUM_SLOT-1:0]  rs_ready_pad;
  entry_t               ren_e, head_e, sel_e;
  logic                 q_empty, head_fire, bypass, fire, push, pop;

  // Widen the ready vector to every encodable FU index; unused slots read 0.
  for (genvar g = 0; g < NUM_SLOT; g++) begin : g_pad
    if (g < NUM_FU) begin : g_used
      assign rs_ready_pad[g] = rs_ready_i[g];
    end else begin : g_free
      assign rs_ready_pad[g] = 1'b0;
    end
  end

  function automatic logic fu_legal(input logic [FU_W-1:0] fu);
    return int'(fu) < NUM_FU;
  endfunction

  // Illegal FUs never wait on an RS: they go straight to the ROB as exceptions.
  function automatic logic fu_ok(input logic [FU_W-1:0] fu, input logic [NUM_SLOT-1:0] rdy);
    return fu_legal(fu) ? rdy[fu] : 1'b1;
  endfunction

  assign ren_e     = '{fu: ren_fu_i, payload: ren_payload_i, rs1: ren_rs1_p_i,
                       rs2: ren_rs2_p_i, rd_new: ren_rd_new_p_i, rd_old: ren_rd_old_p_i};
  assign head_e    = mem[head];
  assign q_empty   = (count == '0);
  assign head_fire = !q_empty && !rob_full_i && fu_ok(head_e.fu, rs_ready_pad) && !flush_i;

`ifdef DISPATCH_QUEUE_BYPASS_EN
  assign bypass = q_empty && ren_valid_i && !rob_full_i && fu_ok(ren_fu_i, rs_ready_pad) && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  assign fire        = head_fire || bypass;
  assign pop         = head_fire;
  assign ren_ready_o = !flush_i && ((count < CNT_W'(DEPTH)) || fire);
  assign push        = ren_valid_i && ren_ready_o && !bypass;
  assign sel_e       = bypass ? ren_e : head_e;

  assign rob_push_o      = fire;
  assign rob_illegal_o   = fire && !fu_legal(sel_e.fu);
  assign disp_payload_o  = sel_e.payload;
  assign disp_rs1_p_o    = sel_e.rs1;
  assign disp_rs2_p_o    = sel_e.rs2;
  assign disp_rd_p_o     = sel_e.rd_new;
  assign disp_rd_old_p_o = sel_e.rd_old;
  assign disp_rob_tag_o  = rob_alloc_tag_i;
  assign count_o         = count;

  always_comb begin
    disp_valid_o = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      disp_valid_o[i] = fire && (int'(sel_e.fu) == i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage is deliberately left unreset; count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= ren_e;
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: directed scenarios followed by random
// traffic, checked every cycle against a queue-based reference model.
module tb_dispatch_queue;

  localparam int DEPTH     = 4;
  localparam int NUM_FU    = 3;
  localparam int FU_W      = 2;
  localparam int PREG_W    = 6;
  localparam int TAG_W     = 4;
  localparam int PAYLOAD_W = 64;
  localparam int CNT_W     = $clog2(DEPTH+1);

  typedef struct packed {
    logic [FU_W-1:0]      fu;
    logic [PAYLOAD_W-1:0] payload;
    logic [PREG_W-1:0]    rs1;
    logic [PREG_W-1:0]    rs2;
    logic [PREG_W-1:0]    rd_new;
    logic [PREG_W-1:0]    rd_old;
  } entry_t;
  localparam int W = $bits(entry_t);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush_i;
  logic                 ren_valid_i;
  logic                 ren_ready_o;
  logic [FU_W-1:0]      ren_fu_i;
  logic [PAYLOAD_W-1:0] ren_payload_i;
  logic [PREG_W-1:0]    ren_rs1_p_i, ren_rs2_p_i, ren_rd_new_p_i, ren_rd_old_p_i;
  logic                 rob_full_i;
  logic [TAG_W-1:0]     rob_alloc_tag_i;
  logic                 rob_push_o, rob_illegal_o;
  logic [NUM_FU-1:0]    rs_ready_i;
  logic [NUM_FU-1:0]    disp_valid_o;
  logic [PAYLOAD_W-1:0] disp_payload_o;
  logic [PREG_W-1:0]    disp_rs1_p_o, disp_rs2_p_o, disp_rd_p_o, disp_rd_old_p_o;
  logic [TAG_W-1:0]     disp_rob_tag_o;
  logic [CNT_W-1:0]     count_o;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  dispatch_queue #(
    .DEPTH(DEPTH), .NUM_FU(NUM_FU), .FU_W(FU_W), .PREG_W(PREG_W),
    .TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .ren_valid_i(ren_valid_i), .ren_ready_o(ren_ready_o), .ren_fu_i(ren_fu_i),
    .ren_payload_i(ren_payload_i), .ren_rs1_p_i(ren_rs1_p_i), .ren_rs2_p_i(ren_rs2_p_i),
    .ren_rd_new_p_i(ren_rd_new_p_i), .ren_rd_old_p_i(ren_rd_old_p_i),
    .rob_full_i(rob_full_i), .rob_alloc_tag_i(rob_alloc_tag_i),
    .rob_push_o(rob_push_o), .rob_illegal_o(rob_illegal_o),
    .rs_ready_i(rs_ready_i), .disp_valid_o(disp_valid_o),
    .disp_payload_o(disp_payload_o), .disp_rs1_p_o(disp_rs1_p_o),
    .disp_rs2_p_o(disp_rs2_p_o), .disp_rd_p_o(disp_rd_p_o),
    .disp_rd_old_p_o(disp_rd_old_p_o), .disp_rob_tag_o(disp_rob_tag_o),
    .count_o(count_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_ren(input logic v, input logic [FU_W-1:0] fu, input logic [PREG_W-1:0] rd);
    ren_valid_i    = v;
    ren_fu_i       = fu;
    ren_rd_new_p_i = rd;
    ren_payload_i  = {$urandom, $urandom};
    ren_rs1_p_i    = PREG_W'($urandom);
    ren_rs2_p_i    = PREG_W'($urandom);
    ren_rd_old_p_i = PREG_W'($urandom);
  endtask

  task automatic drive_random();
    drive_ren($urandom_range(0, 9) < 7, FU_W'($urandom_range(0, 3)), PREG_W'($urandom));
    rs_ready_i      = NUM_FU'($urandom);
    rob_full_i      = $urandom_range(0, 3) == 0;
    flush_i         = $urandom_range(0, 31) == 0;
    rob_alloc_tag_i = TAG_W'($urandom);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic is_legal(input logic [FU_W-1:0] fu);
    return int'(fu) < NUM_FU;
  endfunction

  function automatic logic can_go(input logic [FU_W-1:0] fu, input logic [NUM_FU-1:0] rdy);
    logic r;
    r = !is_legal(fu);
    for (int i = 0; i < NUM_FU; i++) if (int'(fu) == i) r = rdy[i];
    return r;
  endfunction

  // Reference: the queue holds accepted instructions oldest-first; only the
  // oldest may leave, and only when the ROB and its RS (if any) can take it.
  always @(negedge clk) begin : monitor
    entry_t            h, ren_e;
    logic              fire, byp, ready;
    logic [NUM_FU-1:0] exp_dv;
    int                sz;
    if (rst) begin
      exp_q.delete();
    end else begin
      sz    = exp_q.size();
      ren_e = '{fu: ren_fu_i, payload: ren_payload_i, rs1: ren_rs1_p_i,
                rs2: ren_rs2_p_i, rd_new: ren_rd_new_p_i, rd_old: ren_rd_old_p_i};
      h     = '0;
      fire  = 1'b0;
      byp   = 1'b0;
      if (!flush_i && !rob_full_i) begin
        if (sz > 0) begin
          h    = entry_t'(exp_q[0]);
          fire = can_go(h.fu, rs_ready_i);
        end
`ifdef DISPATCH_QUEUE_BYPASS_EN
        else if (ren_valid_i && can_go(ren_fu_i, rs_ready_i)) begin
          h    = ren_e;
          fire = 1'b1;
          byp  = 1'b1;
        end
`endif
      end
      ready  = !flush_i && (sz < DEPTH || fire);
      exp_dv = '0;
      for (int i = 0; i < NUM_FU; i++) if (fire && int'(h.fu) == i) exp_dv[i] = 1'b1;

      check("count",       64'(count_o),       64'(sz));
      check("ren_ready",   64'(ren_ready_o),   64'(ready));
      check("rob_push",    64'(rob_push_o),    64'(fire));
      check("rob_illegal", 64'(rob_illegal_o), 64'(fire && !is_legal(h.fu)));
      check("disp_valid",  64'(disp_valid_o),  64'(exp_dv));
      if (fire) begin
        check("payload", disp_payload_o,          h.payload);
        check("rs1",     64'(disp_rs1_p_o),       64'(h.rs1));
        check("rs2",     64'(disp_rs2_p_o),       64'(h.rs2));
        check("rd",      64'(disp_rd_p_o),        64'(h.rd_new));
        check("rd_old",  64'(disp_rd_old_p_o),    64'(h.rd_old));
        check("rob_tag", 64'(disp_rob_tag_o),     64'(rob_alloc_tag_i));
      end

      if (flush_i) begin
        exp_q.delete();
      end else begin
        if (fire && !byp) void'(exp_q.pop_front());
        if (ren_valid_i && ready && !byp) exp_q.push_back(W'(ren_e));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    flush_i = 1'b0;
    rob_full_i = 1'b0;
    rob_alloc_tag_i = '0;
    rs_ready_i = '0;
    drive_ren(1'b0, '0, '0);
    step(2);
    rst = 1'b0;
    step(1);

    // single ALU op
    rs_ready_i = 3'b111;
    rob_alloc_tag_i = 4'd5;
    drive_ren(1'b1, 2'd0, 6'd12);
    step(1);
    drive_ren(1'b0, 2'd0, 6'd0);
    step(2);

    // fill, then push+pop at full occupancy, then drain
    rs_ready_i = 3'b000;
    for (int i = 0; i < 5; i++) begin
      drive_ren(1'b1, FU_W'(i % 3), PREG_W'(20 + i));
      step(1);
    end
    rs_ready_i = 3'b111;
    for (int i = 0; i < 4; i++) begin
      drive_ren(1'b1, FU_W'(i % 3), PREG_W'(30 + i));
      step(1);
    end
    drive_ren(1'b0, 2'd0, 6'd0);
    step(6);

    // blocked LSU head with a younger ALU behind it
    rs_ready_i = 3'b101;
    drive_ren(1'b1, 2'd1, 6'd40);
    step(1);
    drive_ren(1'b1, 2'd0, 6'd41);
    step(1);
    drive_ren(1'b0, 2'd0, 6'd0);
    step(3);
    rs_ready_i = 3'b111;
    step(3);

    // ROB full with two entries waiting
    rob_full_i = 1'b1;
    drive_ren(1'b1, 2'd0, 6'd50);
    step(1);
    drive_ren(1'b1, 2'd2, 6'd51);
    step(1);
    drive_ren(1'b0, 2'd0, 6'd0);
    step(2);
    rob_full_i = 1'b0;
    step(3);

    // illegal FU
    drive_ren(1'b1, 2'd3, 6'd60);
    step(1);
    drive_ren(1'b0, 2'd0, 6'd0);
    step(2);

    // flush with three queued, Rename still presenting
    rs_ready_i = 3'b000;
    for (int i = 0; i < 3; i++) begin
      drive_ren(1'b1, 2'd0, PREG_W'(61 + i));
      step(1);
    end
    flush_i = 1'b1;
    drive_ren(1'b1, 2'd0, 6'd1);
    step(1);
    flush_i = 1'b0;
    drive_ren(1'b0, 2'd0, 6'd0);
    rs_ready_i = 3'b111;
    step(3);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      step(1);
    end
    flush_i = 1'b0;
    rob_full_i = 1'b0;
    rs_ready_i = 3'b111;
    drive_ren(1'b0, 2'd0, 6'd0);
    step(8);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
